// File: rtl/komandara_k10_pkg.sv
// Shared definitions for the K10 peripheral interconnect: AXI response codes and
// the state encodings of the AXI4-Lite demux read/write FSMs.
package komandara_k10_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FWD  = 2'd1,
        W_RESP = 2'd2
    } axil_wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_FWD  = 2'd1,
        R_RESP = 2'd2
    } axil_rd_state_e;

endpackage

// File: rtl/k10_axil_decode.sv
// Combinational address decoder: base/mask window match per slave, lowest index wins,
// one-hot select plus a miss flag when no window matches.
module k10_axil_decode #(
    parameter int                        N_SLV    = 4,
    parameter int                        ADDR_W   = 32,
    parameter logic [N_SLV*ADDR_W-1:0]   SLV_BASE = {N_SLV{32'h4000_0000}},
    parameter logic [N_SLV*ADDR_W-1:0]   SLV_MASK = {N_SLV{32'hFFFF_F000}}
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic [N_SLV-1:0]  o_sel,
    output logic              o_miss
);

    logic w_found;

    always_comb begin
        o_sel   = '0;
        w_found = 1'b0;
        for (int i = 0; i < N_SLV; i++) begin
            if (!w_found &&
                ((i_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
                o_sel[i] = 1'b1;
                w_found  = 1'b1;
            end
        end
        o_miss = !w_found;
    end

endmodule

// File: rtl/k10_axil_demux.sv
// 1-to-N AXI4-Lite demultiplexer for the K10 peripheral port. Independent read and write
// FSMs, one transaction in flight per direction, unmapped addresses answered with DECERR.
module k10_axil_demux
    import komandara_k10_pkg::*;
#(
    parameter int                        N_SLV    = 4,
    parameter int                        ADDR_W   = 32,
    parameter int                        DATA_W   = 32,
    parameter logic [N_SLV*ADDR_W-1:0]   SLV_BASE = {N_SLV{32'h4000_0000}},
    parameter logic [N_SLV*ADDR_W-1:0]   SLV_MASK = {N_SLV{32'hFFFF_F000}},
    localparam int                       STRB_W   = DATA_W/8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    // upstream
    input  logic [ADDR_W-1:0]          s_axi_awaddr,
    input  logic [2:0]                 s_axi_awprot,
    input  logic                       s_axi_awvalid,
    output logic                       s_axi_awready,
    input  logic [DATA_W-1:0]          s_axi_wdata,
    input  logic [STRB_W-1:0]          s_axi_wstrb,
    input  logic                       s_axi_wvalid,
    output logic                       s_axi_wready,
    output logic [1:0]                 s_axi_bresp,
    output logic                       s_axi_bvalid,
    input  logic                       s_axi_bready,
    input  logic [ADDR_W-1:0]          s_axi_araddr,
    input  logic [2:0]                 s_axi_arprot,
    input  logic                       s_axi_arvalid,
    output logic                       s_axi_arready,
    output logic [DATA_W-1:0]          s_axi_rdata,
    output logic [1:0]                 s_axi_rresp,
    output logic                       s_axi_rvalid,
    input  logic                       s_axi_rready,
    // downstream, slave i at slice i
    output logic [N_SLV*ADDR_W-1:0]    m_axi_awaddr,
    output logic [N_SLV*3-1:0]         m_axi_awprot,
    output logic [N_SLV-1:0]           m_axi_awvalid,
    input  logic [N_SLV-1:0]           m_axi_awready,
    output logic [N_SLV*DATA_W-1:0]    m_axi_wdata,
    output logic [N_SLV*STRB_W-1:0]    m_axi_wstrb,
    output logic [N_SLV-1:0]           m_axi_wvalid,
    input  logic [N_SLV-1:0]           m_axi_wready,
    input  logic [N_SLV*2-1:0]         m_axi_bresp,
    input  logic [N_SLV-1:0]           m_axi_bvalid,
    output logic [N_SLV-1:0]           m_axi_bready,
    output logic [N_SLV*ADDR_W-1:0]    m_axi_araddr,
    output logic [N_SLV*3-1:0]         m_axi_arprot,
    output logic [N_SLV-1:0]           m_axi_arvalid,
    input  logic [N_SLV-1:0]           m_axi_arready,
    input  logic [N_SLV*DATA_W-1:0]    m_axi_rdata,
    input  logic [N_SLV*2-1:0]         m_axi_rresp,
    input  logic [N_SLV-1:0]           m_axi_rvalid,
    output logic [N_SLV-1:0]           m_axi_rready,
    // status
    output logic                       o_decerr_wr,
    output logic                       o_decerr_rd,
    output axil_wr_state_e             o_wr_state,
    output axil_rd_state_e             o_rd_state
);

    // Handshake rule on every channel: a transfer happens on a rising clock edge where
    // valid && ready; once raised, valid and its payload stay stable until that edge.

    logic [N_SLV-1:0] w_aw_sel, w_ar_sel;
    logic             w_aw_miss, w_ar_miss;

    k10_axil_decode #(
        .N_SLV(N_SLV), .ADDR_W(ADDR_W), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)
    ) u_aw_decode (
        .i_addr(s_axi_awaddr), .o_sel(w_aw_sel), .o_miss(w_aw_miss)
    );

    k10_axil_decode #(
        .N_SLV(N_SLV), .ADDR_W(ADDR_W), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)
    ) u_ar_decode (
        .i_addr(s_axi_araddr), .o_sel(w_ar_sel), .o_miss(w_ar_miss)
    );

    axil_wr_state_e     r_wr_state, w_wr_state_nxt;
    logic [ADDR_W-1:0]  r_aw_addr;
    logic [2:0]         r_aw_prot;
    logic [N_SLV-1:0]   r_wr_sel;
    logic               r_wr_miss;
    logic               r_aw_done, w_aw_done_nxt;
    logic               r_w_done, w_w_done_nxt;

    axil_rd_state_e     r_rd_state, w_rd_state_nxt;
    logic [ADDR_W-1:0]  r_ar_addr;
    logic [2:0]         r_ar_prot;
    logic [N_SLV-1:0]   r_rd_sel;
    logic               r_rd_miss;

    // Responses/readies of the currently selected slave (sel is one-hot, so OR is a mux).
    logic               w_sel_awready, w_sel_wready, w_sel_bvalid;
    logic [1:0]         w_sel_bresp;
    logic               w_sel_arready, w_sel_rvalid;
    logic [1:0]         w_sel_rresp;
    logic [DATA_W-1:0]  w_sel_rdata;

    always_comb begin
        w_sel_awready = 1'b0;
        w_sel_wready  = 1'b0;
        w_sel_bvalid  = 1'b0;
        w_sel_bresp   = '0;
        w_sel_arready = 1'b0;
        w_sel_rvalid  = 1'b0;
        w_sel_rresp   = '0;
        w_sel_rdata   = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (r_wr_sel[i]) begin
                w_sel_awready = w_sel_awready | m_axi_awready[i];
                w_sel_wready  = w_sel_wready  | m_axi_wready[i];
                w_sel_bvalid  = w_sel_bvalid  | m_axi_bvalid[i];
                w_sel_bresp   = w_sel_bresp   | m_axi_bresp[i*2 +: 2];
            end
            if (r_rd_sel[i]) begin
                w_sel_arready = w_sel_arready | m_axi_arready[i];
                w_sel_rvalid  = w_sel_rvalid  | m_axi_rvalid[i];
                w_sel_rresp   = w_sel_rresp   | m_axi_rresp[i*2 +: 2];
                w_sel_rdata   = w_sel_rdata   | m_axi_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_state <= W_IDLE;
            r_aw_addr  <= '0;
            r_aw_prot  <= '0;
            r_wr_sel   <= '0;
            r_wr_miss  <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_aw_done  <= w_aw_done_nxt;
            r_w_done   <= w_w_done_nxt;
            if (r_wr_state == W_IDLE && s_axi_awvalid) begin
                r_aw_addr <= s_axi_awaddr;
                r_aw_prot <= s_axi_awprot;
                r_wr_sel  <= w_aw_sel;
                r_wr_miss <= w_aw_miss;
            end
        end
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_aw_done_nxt  = r_aw_done;
        w_w_done_nxt   = r_w_done;
        s_axi_awready  = 1'b0;
        s_axi_wready   = 1'b0;
        s_axi_bvalid   = 1'b0;
        s_axi_bresp    = AXI_RESP_OKAY;
        m_axi_awvalid  = '0;
        m_axi_awaddr   = '0;
        m_axi_awprot   = '0;
        m_axi_wvalid   = '0;
        m_axi_wdata    = '0;
        m_axi_wstrb    = '0;
        m_axi_bready   = '0;
        o_decerr_wr    = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                s_axi_awready = 1'b1;
                if (s_axi_awvalid) begin
                    w_wr_state_nxt = W_FWD;
                    w_aw_done_nxt  = 1'b0;
                    w_w_done_nxt   = 1'b0;
                end
            end
            W_FWD: begin
                if (r_wr_miss) begin
                    s_axi_wready = 1'b1;
                    if (s_axi_wvalid) w_wr_state_nxt = W_RESP;
                end else begin
                    for (int i = 0; i < N_SLV; i++) begin
                        if (r_wr_sel[i]) begin
                            if (!r_aw_done) begin
                                m_axi_awvalid[i]              = 1'b1;
                                m_axi_awaddr[i*ADDR_W +: ADDR_W] = r_aw_addr;
                                m_axi_awprot[i*3 +: 3]        = r_aw_prot;
                            end
                            if (!r_w_done) begin
                                m_axi_wvalid[i]                  = s_axi_wvalid;
                                m_axi_wdata[i*DATA_W +: DATA_W]  = s_axi_wdata;
                                m_axi_wstrb[i*STRB_W +: STRB_W]  = s_axi_wstrb;
                            end
                        end
                    end
                    s_axi_wready = !r_w_done && w_sel_wready;
                    if (!r_aw_done && w_sel_awready) w_aw_done_nxt = 1'b1;
                    if (s_axi_wready && s_axi_wvalid) w_w_done_nxt = 1'b1;
                    if (w_aw_done_nxt && w_w_done_nxt) w_wr_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (r_wr_miss) begin
                    s_axi_bvalid = 1'b1;
                    s_axi_bresp  = AXI_RESP_DECERR;
                end else begin
                    s_axi_bvalid = w_sel_bvalid;
                    s_axi_bresp  = w_sel_bresp;
                    m_axi_bready = r_wr_sel & {N_SLV{s_axi_bready}};
                end
                if (s_axi_bvalid && s_axi_bready) begin
                    w_wr_state_nxt = W_IDLE;
                    o_decerr_wr    = r_wr_miss;
                end
            end
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_state <= R_IDLE;
            r_ar_addr  <= '0;
            r_ar_prot  <= '0;
            r_rd_sel   <= '0;
            r_rd_miss  <= 1'b0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            if (r_rd_state == R_IDLE && s_axi_arvalid) begin
                r_ar_addr <= s_axi_araddr;
                r_ar_prot <= s_axi_arprot;
                r_rd_sel  <= w_ar_sel;
                r_rd_miss <= w_ar_miss;
            end
        end
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        s_axi_arready  = 1'b0;
        s_axi_rvalid   = 1'b0;
        s_axi_rdata    = '0;
        s_axi_rresp    = AXI_RESP_OKAY;
        m_axi_arvalid  = '0;
        m_axi_araddr   = '0;
        m_axi_arprot   = '0;
        m_axi_rready   = '0;
        o_decerr_rd    = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                s_axi_arready = 1'b1;
                if (s_axi_arvalid) w_rd_state_nxt = R_FWD;
            end
            R_FWD: begin
                if (r_rd_miss) begin
                    w_rd_state_nxt = R_RESP;
                end else begin
                    for (int i = 0; i < N_SLV; i++) begin
                        if (r_rd_sel[i]) begin
                            m_axi_arvalid[i]                 = 1'b1;
                            m_axi_araddr[i*ADDR_W +: ADDR_W] = r_ar_addr;
                            m_axi_arprot[i*3 +: 3]           = r_ar_prot;
                        end
                    end
                    if (w_sel_arready) w_rd_state_nxt = R_RESP;
                end
            end
            R_RESP: begin
                if (r_rd_miss) begin
                    s_axi_rvalid = 1'b1;
                    s_axi_rresp  = AXI_RESP_DECERR;
                end else begin
                    s_axi_rvalid = w_sel_rvalid;
                    s_axi_rdata  = w_sel_rdata;
                    s_axi_rresp  = w_sel_rresp;
                    m_axi_rready = r_rd_sel & {N_SLV{s_axi_rready}};
                end
                if (s_axi_rvalid && s_axi_rready) begin
                    w_rd_state_nxt = R_IDLE;
                    o_decerr_rd    = r_rd_miss;
                end
            end
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    assign o_wr_state = r_wr_state;
    assign o_rd_state = r_rd_state;

endmodule
